monitor_cuenta: RTL and testbench
=================================

MONITOR_CUENTA -- requirements
Module: monitor_cuenta

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, which sets the width of the observed count.
REQ-002 SHALL provide parameter MAX_MISS, default 3, which sets the number of consecutive mismatches that cause loss of lock.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: monitor enable.
REQ-006 SHALL have port cuenta, input, WIDTH bits: observed counter value.
REQ-007 SHALL have port up_down, input, 1 bit: observed direction (1 = up, 0 = down).
REQ-008 SHALL have port dut_rst, input, 1 bit: observed synchronous reset of the counter, active-high.
REQ-009 SHALL have port clr_err, input, 1 bit: synchronous clear of error statistics.
REQ-010 SHALL have port esperado, output, WIDTH bits: expected value for the current sample.
REQ-011 SHALL have port error, output, 1 bit: one-cycle pulse on mismatch.
REQ-012 SHALL have port err_count, output, 16 bits: saturating mismatch total.
REQ-013 SHALL have port sincronizado, output, 1 bit: monitor locked to the counter.
REQ-014 SHALL have port err_obs, output, WIDTH bits: observed value at the first mismatch since clear.
REQ-015 SHALL have port err_exp, output, WIDTH bits: expected value at the first mismatch since clear.

Function
REQ-016 SHALL sample cuenta, up_down and dut_rst on every rising clk edge while en=1; S(n), U(n), R(n) denote the samples at edge n.
REQ-017 SHALL compute the prediction E(n+1) as follows: 0 if R(n)=1; else (S(n)+1) mod 2^WIDTH if U(n)=1; else (S(n)-1) mod 2^WIDTH.
REQ-018 SHALL treat 2^WIDTH-1 -> 0 (up) and 0 -> 2^WIDTH-1 (down) as legal transitions, not errors.
REQ-019 SHALL implement the FSM states IDLE, SYNC, TRACK and LOST.
REQ-020 SHALL transition IDLE -> SYNC on the edge where en=1 is sampled; no comparison occurs in IDLE.
REQ-021 SHALL, in SYNC, capture S(n) with no comparison and then go to TRACK on the next edge.
REQ-022 SHALL, in TRACK, compare S(n+1) against E(n+1) at edge n+1.
REQ-023 SHALL, on a TRACK mismatch, register error=1 for exactly the one cycle following edge n+1.
REQ-024 SHALL, on a TRACK mismatch, increment err_count, saturating at 0xFFFF.
REQ-025 SHALL, on a TRACK mismatch, increment a consecutive-miss counter.
REQ-026 SHALL resync after a mismatch: the next prediction is based on the observed S(n+1), not on E(n+1).
REQ-027 SHALL clear the consecutive-miss counter on any TRACK match.
REQ-028 SHALL go TRACK -> LOST when the consecutive-miss count reaches MAX_MISS.
REQ-029 SHALL, in LOST, hold sincronizado=0, suppress error pulses, and leave err_count unchanged.
REQ-030 SHALL go LOST -> TRACK on the first edge where S(n+1)=E(n+1), and clear the consecutive-miss counter.
REQ-031 SHALL drive sincronizado=1 only while in TRACK.
REQ-032 SHALL drive esperado=E for the current cycle in TRACK and LOST, and hold its last value in IDLE and SYNC.
REQ-033 SHALL, on the first mismatch after reset or clr_err, capture err_obs=S(n+1) and err_exp=E(n+1); later mismatches do not update these captures.
REQ-034 SHALL, when clr_err=1, zero err_count, err_obs, err_exp and the first-error flag on that edge.
REQ-035 SHALL, when clr_err and a mismatch occur on the same edge, count the mismatch: err_count=1 and the mismatch is captured as the first.
REQ-036 SHALL, on en=0, go to IDLE on the next edge from any state and hold err_count, err_obs and err_exp.
REQ-037 SHALL keep err_count at 0xFFFF on further mismatches after saturation.

Reset
REQ-038 SHALL, while rst=0 and asynchronously, force state=IDLE and zero esperado, err_count, err_obs, err_exp and the consecutive-miss counter.
REQ-039 SHALL, while rst=0 and asynchronously, hold error=0 and sincronizado=0.
REQ-040 SHALL, on deassertion of rst, leave the block in IDLE, and en must be sampled high before tracking starts.
REQ-041 SHALL, when rst is asserted mid-TRACK, clear all state immediately without waiting for a clk edge.

Verification
REQ-042 SHALL cover: en=1, up_down=1, cuenta 0..150 one step per cycle -> error never asserted, err_count=0, sincronizado=1 from the third edge.
REQ-043 SHALL cover: up sequence 253,254,255,0,1, then down sequence 1,0,255,254 -> no error, esperado equals cuenta each cycle.
REQ-044 SHALL cover: up sequence 10,11,13,14 -> one error pulse at 13, err_count=1, err_obs=13, err_exp=12, no error at 14, sincronizado stays 1.
REQ-045 SHALL cover: three consecutive bad samples (MAX_MISS=3) -> err_count=3, state LOST, sincronizado=0; then one consistent step -> sincronizado=1.
REQ-046 SHALL cover: dut_rst=1 with cuenta=100, then cuenta=0 next cycle -> no error; afterwards, clr_err=1 on the same edge as a mismatch -> err_count=1.
REQ-047 SHALL cover: rst=0 pulse between clock edges mid-TRACK -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/monitor_cuenta.sv
// -----------------------------------------------------------------------------
// monitor_cuenta
//
// Watches an up/down counter with a synchronous reset and checks every sample
// against the value predicted from the previous sample. It locks onto the
// counter, reports each mismatch with a one-cycle pulse and keeps error
// statistics. After MAX_MISS consecutive mismatches it declares loss of lock
// and waits for the counter to become consistent again.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   en           monitor enable; low returns the monitor to IDLE
//   cuenta       observed counter value
//   up_down      observed direction (1 = up, 0 = down)
//   dut_rst      observed synchronous reset of the counter (active high)
//   clr_err      synchronous clear of the error statistics
//   esperado     value expected for the sample of the current cycle
//   error        one-cycle pulse after a mismatch while locked
//   err_count    saturating total of counted mismatches
//   sincronizado high while the monitor is locked (TRACK)
//   err_obs      observed value of the first mismatch since clear
//   err_exp      expected value of the first mismatch since clear
// -----------------------------------------------------------------------------
module monitor_cuenta #(
    parameter int WIDTH    = 8,
    parameter int MAX_MISS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cuenta,
    input  logic             up_down,
    input  logic             dut_rst,
    input  logic             clr_err,
    output logic [WIDTH-1:0] esperado,
    output logic             error,
    output logic [15:0]      err_count,
    output logic             sincronizado,
    output logic [WIDTH-1:0] err_obs,
    output logic [WIDTH-1:0] err_exp
);

    localparam int             MW       = $clog2(MAX_MISS + 1);
    localparam logic [MW-1:0]  MISS_LIM = MW'(MAX_MISS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        LOST  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [MW-1:0]    miss_cnt;
    logic [MW-1:0]    miss_inc;
    logic [WIDTH-1:0] pred;
    logic             mismatch;
    logic             hit;
    logic             first_err;

    // Value the counter should show on the next edge, given this sample.
    // Wrap-around in either direction is the natural modulo behaviour.
    function automatic logic [WIDTH-1:0] next_value(
        input logic [WIDTH-1:0] s,
        input logic             up,
        input logic             r
    );
        if (r)
            return '0;
        else if (up)
            return s + WIDTH'(1);
        else
            return s - WIDTH'(1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        pred     = next_value(cuenta, up_down, dut_rst);
        mismatch = (cuenta != esperado);
        miss_inc = miss_cnt + MW'(1);
        // Only mismatches seen while locked are reported and counted.
        hit      = en && (state == TRACK) && mismatch;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        sincronizado = (state == TRACK);
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = SYNC;
                SYNC:  state_nxt = TRACK;
                TRACK: if (mismatch && (miss_inc >= MISS_LIM)) state_nxt = LOST;
                LOST:  if (!mismatch) state_nxt = TRACK;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Prediction and consecutive-miss tracking. The prediction is always
    // rebuilt from the observed sample, so a mismatch resynchronises it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            esperado <= '0;
            miss_cnt <= '0;
            error    <= 1'b0;
        end else begin
            error <= hit;
            if (en) begin
                if (state != IDLE)
                    esperado <= pred;
                case (state)
                    SYNC:    miss_cnt <= '0;
                    TRACK:   miss_cnt <= mismatch ? miss_inc : '0;
                    LOST:    if (!mismatch) miss_cnt <= '0;
                    default: miss_cnt <= miss_cnt;
                endcase
            end
        end
    end

    // Error statistics. A clear on the same edge as a counted mismatch
    // still records that mismatch as the first one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
            err_obs   <= '0;
            err_exp   <= '0;
            first_err <= 1'b0;
        end else if (clr_err) begin
            err_count <= hit ? 16'd1 : 16'd0;
            err_obs   <= hit ? cuenta : '0;
            err_exp   <= hit ? esperado : '0;
            first_err <= hit;
        end else if (hit) begin
            err_count <= sat_inc(err_count);
            if (!first_err) begin
                err_obs   <= cuenta;
                err_exp   <= esperado;
                first_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_monitor_cuenta.sv
module tb_monitor_cuenta;
    localparam int W    = 8;
    localparam int MAXM = 3;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, up_down, dut_rst, clr_err;
    logic [W-1:0] cuenta;
    logic [W-1:0] esperado, err_obs, err_exp;
    logic         error, sincronizado;
    logic [15:0]  err_count;

    monitor_cuenta #(.WIDTH(W), .MAX_MISS(MAXM)) dut (
        .clk(clk), .rst(rst), .en(en), .cuenta(cuenta), .up_down(up_down),
        .dut_rst(dut_rst), .clr_err(clr_err), .esperado(esperado), .error(error),
        .err_count(err_count), .sincronizado(sincronizado),
        .err_obs(err_obs), .err_exp(err_exp)
    );

    // Second instance with a huge miss limit, used to reach counter saturation.
    logic         s_rst, s_en, s_up, s_drst, s_clr;
    logic [W-1:0] s_cuenta, s_esperado, s_obs, s_exp;
    logic         s_error, s_sinc;
    logic [15:0]  s_count;

    monitor_cuenta #(.WIDTH(W), .MAX_MISS(70000)) sat_dut (
        .clk(clk), .rst(s_rst), .en(s_en), .cuenta(s_cuenta), .up_down(s_up),
        .dut_rst(s_drst), .clr_err(s_clr), .esperado(s_esperado), .error(s_error),
        .err_count(s_count), .sincronizado(s_sinc),
        .err_obs(s_obs), .err_exp(s_exp)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 sync, 2 locked, 3 lost.
    int m_phase, m_pred, m_cnt, m_obs, m_exp, m_miss;
    bit m_first, m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pred = 0; m_cnt = 0; m_obs = 0; m_exp = 0;
        m_miss = 0; m_first = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit e, input int c, input bit u, input bit r, input bit clr);
        bit mis, counted;
        int old;
        mis     = (c != m_pred);
        counted = e && (m_phase == 2) && mis;
        m_err   = counted;
        if (clr) begin
            m_cnt = 0; m_first = 0; m_obs = 0; m_exp = 0;
        end
        if (counted) begin
            if (m_cnt < 65535) m_cnt++;
            if (!m_first) begin
                m_first = 1; m_obs = c; m_exp = m_pred;
            end
        end
        if (!e) begin
            m_phase = 0;
        end else begin
            old = m_phase;
            if (old == 0) m_phase = 1;
            else if (old == 1) begin m_phase = 2; m_miss = 0; end
            else if (old == 2) begin
                if (mis) begin
                    m_miss++;
                    if (m_miss >= MAXM) m_phase = 3;
                end else m_miss = 0;
            end else if (!mis) begin
                m_phase = 2; m_miss = 0;
            end
            if (old != 0)
                m_pred = r ? 0 : (u ? (c + 1) % 256 : (c + 255) % 256);
        end
    endtask

    task automatic check_all();
        check("error", 32'(error), 32'(m_err));
        check("sincronizado", 32'(sincronizado), 32'(m_phase == 2));
        check("esperado", 32'(esperado), m_pred);
        check("err_count", 32'(err_count), m_cnt);
        check("err_obs", 32'(err_obs), m_obs);
        check("err_exp", 32'(err_exp), m_exp);
    endtask

    task automatic step(input bit e, input int c, input bit u, input bit r, input bit clr);
        en = e; cuenta = W'(c); up_down = u; dut_rst = r; clr_err = clr;
        @(posedge clk);
        model_edge(e, c, u, r, clr);
        #1;
        check_all();
    endtask

    initial begin
        int seq_c[8];
        bit seq_u[8];
        int c;
        bit e, u, r, clr;

        rst = 1'b0; en = 1'b0; cuenta = '0; up_down = 1'b1; dut_rst = 1'b0; clr_err = 1'b0;
        s_rst = 1'b0; s_en = 1'b1; s_cuenta = '0; s_up = 1'b1; s_drst = 1'b0; s_clr = 1'b0;
        model_reset();
        #12;
        check_all();
        check("reset_state_idle", 32'(sincronizado), 32'd0);
        rst = 1'b1;

        // Clean up-count 0..150.
        for (int i = 0; i <= 150; i++) step(1, i, 1, 0, 0);
        check("count_run_errors", 32'(err_count), 32'd0);
        check("count_run_lock", 32'(sincronizado), 32'd1);

        // Wrap-around up and down.
        step(0, 0, 1, 0, 0);
        seq_c = '{253, 254, 255, 0, 1, 0, 255, 254};
        seq_u = '{1, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            if (m_phase == 2) check("esperado_eq_cuenta", 32'(esperado), seq_c[i]);
            step(1, seq_c[i], seq_u[i], 0, 0);
        end
        check("wrap_no_error", 32'(err_count), 32'd0);

        // Single skipped value.
        step(0, 0, 1, 0, 1);
        step(1, 10, 1, 0, 0);
        step(1, 11, 1, 0, 0);
        step(1, 13, 1, 0, 0);
        check("skip_pulse", 32'(error), 32'd1);
        check("skip_count", 32'(err_count), 32'd1);
        check("skip_obs", 32'(err_obs), 32'd13);
        check("skip_exp", 32'(err_exp), 32'd12);
        step(1, 14, 1, 0, 0);
        check("skip_resync", 32'(error), 32'd0);
        check("skip_lock", 32'(sincronizado), 32'd1);

        // Three consecutive bad samples, then recovery.
        step(1, 15, 1, 0, 1);
        step(1, 50, 1, 0, 0);
        step(1, 70, 1, 0, 0);
        step(1, 90, 1, 0, 0);
        check("lost_count", 32'(err_count), 32'd3);
        check("lost_lock", 32'(sincronizado), 32'd0);
        step(1, 200, 1, 0, 0);
        check("lost_no_pulse", 32'(error), 32'd0);
        check("lost_count_held", 32'(err_count), 32'd3);
        step(1, 201, 1, 0, 0);
        check("relock", 32'(sincronizado), 32'd1);

        // Observed counter reset, then clear on a mismatch edge.
        step(1, 202, 1, 1, 0);
        step(1, 0, 1, 0, 0);
        check("dut_rst_ok", 32'(error), 32'd0);
        step(1, 5, 1, 0, 1);
        check("clr_mis_count", 32'(err_count), 32'd1);
        check("clr_mis_obs", 32'(err_obs), 32'd5);
        check("clr_mis_exp", 32'(err_exp), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            e   = ($urandom_range(0, 19) != 0);
            r   = ($urandom_range(0, 19) == 0);
            clr = ($urandom_range(0, 19) == 0);
            u   = 1'($urandom_range(0, 1));
            if (m_phase < 2 || $urandom_range(0, 3) == 0)
                c = int'($urandom_range(0, 255));
            else
                c = m_pred;
            step(e, c, u, r, clr);
        end

        // Asynchronous reset between edges while locked with errors recorded.
        step(0, 0, 1, 0, 0);
        step(1, 20, 1, 0, 0);
        step(1, 21, 1, 0, 0);
        step(1, 30, 1, 0, 0);
        step(1, 31, 1, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        check("arst_esperado", 32'(esperado), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        check("arst_count", 32'(err_count), 32'd0);
        check("arst_lock", 32'(sincronizado), 32'd0);
        check("arst_obs", 32'(err_obs), 32'd0);
        check("arst_exp", 32'(err_exp), 32'd0);
        model_reset();
        #3;
        rst = 1'b1;
        step(1, 40, 1, 0, 0);
        step(1, 41, 1, 0, 0);
        step(1, 42, 1, 0, 0);
        check("after_arst_lock", 32'(sincronizado), 32'd1);

        // Saturation: every sample mismatches on the second instance.
        #2;
        s_rst = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        check("sat_below", 32'(s_count), 32'hFFFE);
        @(posedge clk);
        #1;
        check("sat_reach", 32'(s_count), 32'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        check("sat_hold", 32'(s_count), 32'hFFFF);
        check("sat_pulse", 32'(s_error), 32'd1);
        check("sat_obs", 32'(s_obs), 32'd0);
        check("sat_exp", 32'(s_exp), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
